// File: rtl/gx_reset_pkg.sv
// Shared types and constants for the per-channel transceiver reset sequencer.
package gx_reset_pkg;

    localparam int SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        TX_ARST,
        TX_WAIT_CAL,
        TX_DRST,
        TX_READY
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_ARST,
        RX_WAIT_CAL,
        RX_WAIT_LOCK,
        RX_DRST,
        RX_READY,
        RX_FAIL
    } rx_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/gx_ch_reset_seq.sv
// One transceiver channel: status synchronisers plus independent TX and RX
// reset state machines. pll_locked_i arrives already synchronised.
module gx_ch_reset_seq
    import gx_reset_pkg::*;
#(
    parameter int T_ANALOG_CYC = 8,
    parameter int T_DIG_CYC    = 8,
    parameter int T_LTD_CYC    = 1024,
    parameter int TIMEOUT_CYC  = 65536,
    parameter int MAX_RETRY    = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pll_locked_i,
    input  logic tx_reset_req_i,
    input  logic rx_reset_req_i,
    input  logic tx_cal_busy_i,
    input  logic rx_cal_busy_i,
    input  logic rx_is_lockedtodata_i,
    output logic tx_analogreset_o,
    output logic tx_digitalreset_o,
    output logic rx_analogreset_o,
    output logic rx_digitalreset_o,
    output logic tx_ready_o,
    output logic rx_ready_o,
    output logic rx_fail_o
);

    localparam int CW = $clog2(max3(T_ANALOG_CYC, T_DIG_CYC, TIMEOUT_CYC) + 1);
    localparam int LW = $clog2(T_LTD_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [CW-1:0] ANA_LAST  = CW'(T_ANALOG_CYC - 1);
    localparam logic [CW-1:0] DIG_LAST  = CW'(T_DIG_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYC - 1);
    localparam logic [LW-1:0] LTD_LAST  = LW'(T_LTD_CYC - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    // Bit order {lockedtodata, rx_cal_busy, tx_cal_busy}; busy resets high, lock low.
    logic [SYNC_DEPTH-1:0][2:0] sync_q;
    logic tx_cal_s, rx_cal_s, ltd_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= {SYNC_DEPTH{3'b011}};
        else         sync_q <= {sync_q[SYNC_DEPTH-2:0],
                                {rx_is_lockedtodata_i, rx_cal_busy_i, tx_cal_busy_i}};
    end

    assign {ltd_s, rx_cal_s, tx_cal_s} = sync_q[SYNC_DEPTH-1];

    tx_state_t       tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [LW-1:0]   lock_q, lock_d;
    logic [RW-1:0]   retry_q, retry_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state_q <= TX_ARST;
            tx_cnt_q   <= '0;
            rx_state_q <= RX_ARST;
            rx_cnt_q   <= '0;
            lock_q     <= '0;
            retry_q    <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            lock_q     <= lock_d;
            retry_q    <= retry_d;
        end
    end

    // Once the analog hold has elapsed, an unlocked PLL parks TX_ARST at its
    // terminal count instead of bouncing through WAIT_CAL.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        if (tx_reset_req_i || (!pll_locked_i && tx_state_q != TX_ARST)) begin
            tx_state_d = TX_ARST;
            tx_cnt_d   = '0;
        end else begin
            case (tx_state_q)
                TX_ARST: begin
                    if (tx_cnt_q != ANA_LAST) begin
                        tx_cnt_d = tx_cnt_q + CW'(1);
                    end else if (pll_locked_i) begin
                        tx_state_d = TX_WAIT_CAL;
                        tx_cnt_d   = '0;
                    end
                end
                TX_WAIT_CAL: begin
                    if (!tx_cal_s) begin
                        tx_state_d = TX_DRST;
                        tx_cnt_d   = '0;
                    end
                end
                TX_DRST: begin
                    if (tx_cnt_q == DIG_LAST) begin
                        tx_state_d = TX_READY;
                        tx_cnt_d   = '0;
                    end else begin
                        tx_cnt_d = tx_cnt_q + CW'(1);
                    end
                end
                TX_READY: ;
                default: begin
                    tx_state_d = TX_ARST;
                    tx_cnt_d   = '0;
                end
            endcase
        end
    end

    // rx_cnt_q times ARST/DRST holds and doubles as the lock timeout.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        lock_d     = lock_q;
        retry_d    = retry_q;
        if (rx_reset_req_i) begin
            rx_state_d = RX_ARST;
            rx_cnt_d   = '0;
            lock_d     = '0;
            retry_d    = '0;
        end else begin
            case (rx_state_q)
                RX_ARST: begin
                    lock_d = '0;
                    if (rx_cnt_q == ANA_LAST) begin
                        rx_state_d = RX_WAIT_CAL;
                        rx_cnt_d   = '0;
                    end else begin
                        rx_cnt_d = rx_cnt_q + CW'(1);
                    end
                end
                RX_WAIT_CAL: begin
                    rx_cnt_d = '0;
                    lock_d   = '0;
                    if (!rx_cal_s) rx_state_d = RX_WAIT_LOCK;
                end
                RX_WAIT_LOCK: begin
                    lock_d = ltd_s ? lock_q + LW'(1) : '0;
                    if (ltd_s && lock_q == LTD_LAST) begin
                        rx_state_d = RX_DRST;
                        rx_cnt_d   = '0;
                        lock_d     = '0;
                    end else if (rx_cnt_q == TMO_LAST) begin
                        rx_cnt_d = '0;
                        lock_d   = '0;
                        if (retry_q < RETRY_MAX) begin
                            retry_d    = retry_q + RW'(1);
                            rx_state_d = RX_ARST;
                        end else begin
                            rx_state_d = RX_FAIL;
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q + CW'(1);
                    end
                end
                RX_DRST: begin
                    if (rx_cnt_q == DIG_LAST) begin
                        rx_state_d = RX_READY;
                        rx_cnt_d   = '0;
                    end else begin
                        rx_cnt_d = rx_cnt_q + CW'(1);
                    end
                end
                RX_READY: begin
                    retry_d = '0;
                    if (!ltd_s) begin
                        rx_state_d = RX_ARST;
                        rx_cnt_d   = '0;
                    end
                end
                RX_FAIL: ;
                default: begin
                    rx_state_d = RX_ARST;
                    rx_cnt_d   = '0;
                end
            endcase
        end
    end

    assign tx_analogreset_o  = (tx_state_q == TX_ARST);
    assign tx_digitalreset_o = (tx_state_q != TX_READY);
    assign tx_ready_o        = (tx_state_q == TX_READY);
    assign rx_analogreset_o  = (rx_state_q == RX_ARST) || (rx_state_q == RX_FAIL);
    assign rx_digitalreset_o = (rx_state_q != RX_READY);
    assign rx_ready_o        = (rx_state_q == RX_READY);
    assign rx_fail_o         = (rx_state_q == RX_FAIL);

endmodule

// File: rtl/gx_std_xn_reset_ctrl.sv
// N-channel transceiver reset controller: one shared PLL-lock synchroniser
// feeding an array of independent per-channel sequencers.
module gx_std_xn_reset_ctrl
    import gx_reset_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int T_ANALOG_CYC = 8,
    parameter int T_DIG_CYC    = 8,
    parameter int T_LTD_CYC    = 1024,
    parameter int TIMEOUT_CYC  = 65536,
    parameter int MAX_RETRY    = 3
) (
    input  logic              reconfig_clk,
    input  logic              reconfig_reset_n,
    input  logic              pll_locked,
    input  logic [NUM_CH-1:0] tx_reset_req,
    input  logic [NUM_CH-1:0] rx_reset_req,
    input  logic [NUM_CH-1:0] tx_cal_busy,
    input  logic [NUM_CH-1:0] rx_cal_busy,
    input  logic [NUM_CH-1:0] rx_is_lockedtodata,
    output logic [NUM_CH-1:0] tx_analogreset,
    output logic [NUM_CH-1:0] tx_digitalreset,
    output logic [NUM_CH-1:0] rx_analogreset,
    output logic [NUM_CH-1:0] rx_digitalreset,
    output logic [NUM_CH-1:0] tx_ready,
    output logic [NUM_CH-1:0] rx_ready,
    output logic [NUM_CH-1:0] rx_fail
);

    logic [SYNC_DEPTH-1:0] pll_sync_q;

    always_ff @(posedge reconfig_clk or negedge reconfig_reset_n) begin
        if (!reconfig_reset_n) pll_sync_q <= '0;
        else                   pll_sync_q <= {pll_sync_q[SYNC_DEPTH-2:0], pll_locked};
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        gx_ch_reset_seq #(
            .T_ANALOG_CYC (T_ANALOG_CYC),
            .T_DIG_CYC    (T_DIG_CYC),
            .T_LTD_CYC    (T_LTD_CYC),
            .TIMEOUT_CYC  (TIMEOUT_CYC),
            .MAX_RETRY    (MAX_RETRY)
        ) u_ch (
            .clk_i                (reconfig_clk),
            .rst_ni               (reconfig_reset_n),
            .pll_locked_i         (pll_sync_q[SYNC_DEPTH-1]),
            .tx_reset_req_i       (tx_reset_req[g]),
            .rx_reset_req_i       (rx_reset_req[g]),
            .tx_cal_busy_i        (tx_cal_busy[g]),
            .rx_cal_busy_i        (rx_cal_busy[g]),
            .rx_is_lockedtodata_i (rx_is_lockedtodata[g]),
            .tx_analogreset_o     (tx_analogreset[g]),
            .tx_digitalreset_o    (tx_digitalreset[g]),
            .rx_analogreset_o     (rx_analogreset[g]),
            .rx_digitalreset_o    (rx_digitalreset[g]),
            .tx_ready_o           (tx_ready[g]),
            .rx_ready_o           (rx_ready[g]),
            .rx_fail_o            (rx_fail[g])
        );
    end

endmodule

// File: tb/tb_gx_std_xn_reset_ctrl.sv
// Table-driven bench: timed stimulus and expected-output tables, expectations
// held in a scoreboard and compared on the cycle they fall due.
module tb_gx_std_xn_reset_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pll;
    logic [N-1:0] tx_req, rx_req, tx_cal, rx_cal, ltd;
    logic [N-1:0] tx_ana, tx_dig, rx_ana, rx_dig, tx_rdy, rx_rdy, rx_fl;

    gx_std_xn_reset_ctrl #(
        .NUM_CH(N), .T_ANALOG_CYC(4), .T_DIG_CYC(4), .T_LTD_CYC(16),
        .TIMEOUT_CYC(64), .MAX_RETRY(2)
    ) dut (
        .reconfig_clk       (clk),
        .reconfig_reset_n   (rst_n),
        .pll_locked         (pll),
        .tx_reset_req       (tx_req),
        .rx_reset_req       (rx_req),
        .tx_cal_busy        (tx_cal),
        .rx_cal_busy        (rx_cal),
        .rx_is_lockedtodata (ltd),
        .tx_analogreset     (tx_ana),
        .tx_digitalreset    (tx_dig),
        .rx_analogreset     (rx_ana),
        .rx_digitalreset    (rx_dig),
        .tx_ready           (tx_rdy),
        .rx_ready           (rx_rdy),
        .rx_fail            (rx_fl)
    );

    always #5 clk = ~clk;

    typedef enum int {S_TXA, S_TXD, S_TXR, S_RXA, S_RXD, S_RXR, S_RXF} sig_e;
    typedef enum int {I_PLL, I_TXC, I_RXC, I_LTD, I_TXQ, I_RXQ} inp_e;
    typedef struct { int at; sig_e sig; logic [N-1:0] val; } exp_t;
    typedef struct { int at; inp_e inp; logic [N-1:0] val; } stim_t;

    exp_t  sb[$];
    exp_t  tbl[$];
    stim_t stq[$];
    int    ecnt, errs, checks;

    function automatic logic [N-1:0] obs(sig_e s);
        case (s)
            S_TXA:   return tx_ana;
            S_TXD:   return tx_dig;
            S_TXR:   return tx_rdy;
            S_RXA:   return rx_ana;
            S_RXD:   return rx_dig;
            S_RXR:   return rx_rdy;
            default: return rx_fl;
        endcase
    endfunction

    task automatic check_due();
        exp_t keep[$];
        logic [N-1:0] act;
        foreach (sb[i]) begin
            if (sb[i].at == ecnt) begin
                act = obs(sb[i].sig);
                checks++;
                if (act !== sb[i].val) begin
                    errs++;
                    $display("FAIL %s@%0d got=%b want=%b", sb[i].sig.name(), sb[i].at, act, sb[i].val);
                end
            end else if (sb[i].at < ecnt) begin
                checks++; errs++;
                $display("FAIL %s@%0d not reached got=%0d want=%0d", sb[i].sig.name(), sb[i].at, ecnt, sb[i].at);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    endtask

    task automatic drain_left();
        foreach (sb[i]) begin
            checks++; errs++;
            $display("FAIL %s@%0d pending got=%0d want=%0d", sb[i].sig.name(), sb[i].at, ecnt, sb[i].at);
        end
        sb.delete();
    endtask

    task automatic expect_reset();
        sb.push_back('{ecnt, S_TXA, 4'hF});
        sb.push_back('{ecnt, S_TXD, 4'hF});
        sb.push_back('{ecnt, S_TXR, 4'h0});
        sb.push_back('{ecnt, S_RXA, 4'hF});
        sb.push_back('{ecnt, S_RXD, 4'hF});
        sb.push_back('{ecnt, S_RXR, 4'h0});
        sb.push_back('{ecnt, S_RXF, 4'h0});
        check_due();
    endtask

    task automatic tick();
        @(posedge clk);
        ecnt++;
        #1;
        check_due();
    endtask

    task automatic apply(input stim_t s);
        case (s.inp)
            I_PLL:   pll    = s.val[0];
            I_TXC:   tx_cal = s.val;
            I_RXC:   rx_cal = s.val;
            I_LTD:   ltd    = s.val;
            I_TXQ:   tx_req = s.val;
            default: rx_req = s.val;
        endcase
    endtask

    task automatic run_to(input int last);
        while (ecnt < last) begin
            tick();
            foreach (stq[i]) if (stq[i].at == ecnt) apply(stq[i]);
        end
    endtask

    initial begin
        errs = 0; checks = 0; ecnt = 0;
        rst_n = 1'b0; pll = 1'b1;
        tx_req = '0; rx_req = '0; tx_cal = '0; rx_cal = '1; ltd = '0;

        repeat (3) @(posedge clk);
        #1;
        expect_reset();

        // Phase 1: power-up, RX lock with glitch on ch1, ch2 retry exhaustion,
        // PLL drop, TX request hold, RX loss of lock on ch3.
        stq = '{ '{19, I_RXC, 4'h0}, '{24, I_LTD, 4'hB}, '{34, I_LTD, 4'h9},
                 '{35, I_LTD, 4'hB}, '{230, I_RXQ, 4'h4}, '{231, I_RXQ, 4'h0},
                 '{240, I_PLL, 4'h0}, '{250, I_PLL, 4'h1}, '{260, I_TXQ, 4'h2},
                 '{270, I_TXQ, 4'h0}, '{280, I_LTD, 4'h3}, '{290, I_LTD, 4'hB} };
        tbl = '{ '{3, S_TXA, 4'hF}, '{3, S_TXD, 4'hF}, '{3, S_TXR, 4'h0},
                 '{3, S_RXA, 4'hF}, '{3, S_RXD, 4'hF},
                 '{4, S_TXA, 4'h0}, '{4, S_TXD, 4'hF}, '{4, S_RXA, 4'h0}, '{4, S_RXD, 4'hF},
                 '{8, S_TXR, 4'h0}, '{8, S_TXD, 4'hF},
                 '{9, S_TXR, 4'hF}, '{9, S_TXD, 4'h0},
                 '{45, S_RXR, 4'h0}, '{45, S_RXD, 4'hF},
                 '{46, S_RXR, 4'h9}, '{46, S_RXD, 4'h6},
                 '{56, S_RXR, 4'h9}, '{57, S_RXR, 4'hB}, '{57, S_RXD, 4'h4},
                 '{85, S_RXA, 4'h0}, '{85, S_RXF, 4'h0}, '{86, S_RXA, 4'h4},
                 '{89, S_RXA, 4'h4}, '{90, S_RXA, 4'h0},
                 '{154, S_RXA, 4'h0}, '{155, S_RXA, 4'h4},
                 '{223, S_RXF, 4'h0}, '{223, S_RXA, 4'h0},
                 '{224, S_RXF, 4'h4}, '{224, S_RXA, 4'h4}, '{224, S_RXD, 4'h4}, '{224, S_RXR, 4'hB},
                 '{231, S_RXF, 4'h0}, '{231, S_RXA, 4'h4},
                 '{234, S_RXA, 4'h4}, '{235, S_RXA, 4'h0},
                 '{242, S_TXR, 4'hF}, '{242, S_TXA, 4'h0},
                 '{243, S_TXR, 4'h0}, '{243, S_TXA, 4'hF}, '{243, S_TXD, 4'hF}, '{243, S_RXR, 4'hB},
                 '{252, S_TXA, 4'hF}, '{253, S_TXA, 4'h0},
                 '{257, S_TXR, 4'h0}, '{258, S_TXR, 4'hF},
                 '{261, S_TXR, 4'hD}, '{261, S_TXA, 4'h2},
                 '{273, S_TXA, 4'h2}, '{274, S_TXA, 4'h0},
                 '{278, S_TXR, 4'hD}, '{279, S_TXR, 4'hF},
                 '{282, S_RXR, 4'hB}, '{283, S_RXR, 4'h3}, '{283, S_RXA, 4'h8},
                 '{299, S_RXA, 4'h0}, '{300, S_RXA, 4'h4} };
        rst_n = 1'b1;
        ecnt  = 0;
        foreach (tbl[i]) sb.push_back(tbl[i]);
        run_to(310);
        drain_left();

        // Asynchronous reset while ch2 sits in WAIT_LOCK with one retry used.
        #3 rst_n = 1'b0;
        #1 expect_reset();
        tick();
        expect_reset();
        tick();
        expect_reset();

        // Phase 2: retry count restarts from zero, so ch2 fails only on the
        // third timeout after release.
        stq.delete();
        tbl = '{ '{9, S_TXR, 4'hF},
                 '{24, S_RXR, 4'h0}, '{25, S_RXR, 4'hB},
                 '{137, S_RXA, 4'h0}, '{137, S_RXF, 4'h0},
                 '{138, S_RXA, 4'h4}, '{138, S_RXF, 4'h0},
                 '{206, S_RXF, 4'h0}, '{207, S_RXF, 4'h4}, '{207, S_RXR, 4'hB} };
        rst_n = 1'b1;
        ecnt  = 0;
        foreach (tbl[i]) sb.push_back(tbl[i]);
        run_to(210);
        drain_left();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
